control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have progData, input, 8 bits: program ROM data; the ROM is addressed by the PC register and has 1-cycle synchronous read latency.
REQ-004 SHALL have inboxEmpty, input, 1 bit: INBOX FIFO empty.
REQ-005 SHALL have outboxFull, input, 1 bit: OUTBOX FIFO full.
REQ-006 SHALL have memData, input, 8 bits: data RAM read data, 1-cycle latency after operand is presented.
REQ-007 SHALL have wPC, output, 1 bit: PC update strobe, 1 cycle wide.
REQ-008 SHALL have branch, output, 1 bit: PC load-jump qualifier.
REQ-009 SHALL have ijump, output, 1 bit: unconditional jump.
REQ-010 SHALL have flagSel, output, 1 bit: ALU flag routed to the PC's aluFlag; 0=Z, 1=N.
REQ-011 SHALL have operand, output, 8 bits: latched operand byte; drives both the PC's jmpAddr and the RAM address.
REQ-012 SHALL have wR, output, 1 bit: register R write strobe.
REQ-013 SHALL have muxR, output, 2 bits: R source; 00=inbox, 01=RAM, 10=ALU.
REQ-014 SHALL have aluOp, output, 2 bits: 00=R+M, 01=R-M, 10=M+1, 11=M-1.
REQ-015 SHALL have wM, output, 1 bit: RAM write strobe.
REQ-016 SHALL have rInbox, output, 1 bit: inbox pop strobe.
REQ-017 SHALL have wOutbox, output, 1 bit: outbox push strobe.
REQ-018 SHALL have halted, output, 1 bit: CPU stopped.

Function
REQ-019 SHALL decode opcode = IR[7:4] as follows:
- 0 INBOX, 1 OUTBOX: 1-byte instructions.
- 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMPUP, 7 BUMPDN, 8 JUMP, 9 JUMPZ, A JUMPN: 2-byte instructions (opcode byte, then operand byte).
- F HALT.
REQ-020 SHALL implement the states FETCH, DECODE, FETCH_OP, LOAD_OP, EXEC, MEM_RD, WAIT_IO and HALT.
REQ-021 FETCH SHALL last 1 cycle, then go to DECODE.
REQ-022 DECODE SHALL do the following:
- Latch IR <= progData.
- Assert wPC with branch=0, so PC+1.
- Go to FETCH_OP for 2-byte instructions, WAIT_IO for INBOX/OUTBOX, HALT for F.
REQ-023 FETCH_OP SHALL idle 1 cycle; LOAD_OP SHALL latch operand <= progData, then go to MEM_RD for RAM reads (COPYFROM, ADD, SUB, BUMP*) or to EXEC otherwise.
REQ-024 EXEC for JUMP/JUMPZ/JUMPN SHALL drive the PC as follows:
- Assert wPC=1 and branch=1.
- Set ijump=1 for JUMP only.
- Set flagSel=0 for JUMPZ, 1 for JUMPN.
- When not taken, the PC increments past the operand byte.
REQ-025 EXEC for the remaining 2-byte instructions SHALL do the following in one cycle, together with wPC=1 and branch=0:
- COPYTO: wM.
- COPYFROM: wR with muxR=01.
- ADD/SUB: wR with muxR=10.
- BUMP*: wR and wM with muxR=10.
REQ-026 WAIT_IO SHALL hold while inboxEmpty=1 (INBOX) or outboxFull=1 (OUTBOX).
REQ-027 On release, WAIT_IO SHALL do the following in one cycle:
- INBOX: assert rInbox and wR with muxR=00.
- OUTBOX: assert wOutbox.
REQ-028 MEM_RD SHALL last exactly 1 cycle, then go to EXEC.
REQ-029 Every instruction SHALL return to FETCH after completion.
REQ-030 HALT SHALL be sticky until rst; halted=1, and all strobes SHALL stay 0.
REQ-031 All strobes (wPC, wR, wM, rInbox, wOutbox) SHALL be single-cycle, never asserted in two consecutive cycles of one instruction, and SHALL be 0 in every state not named above.
REQ-032 Unknown opcodes (B-E) SHALL behave per REQ-037/REQ-038.

Reset
REQ-033 rst=1 SHALL immediately, mid-instruction included, force state=FETCH, IR=0, operand=0, and every output=0.
REQ-034 After rst deasserts, the first FETCH SHALL occur on the next clock edge.

Configuration
REQ-035 Macro INVALID_OPCODE_TRAP_EN SHALL select the unknown-opcode behaviour.
REQ-036 When INVALID_OPCODE_TRAP_EN is defined, the block SHALL have an extra output trap (1 bit, reset 0).
REQ-037 With INVALID_OPCODE_TRAP_EN defined, opcodes B-E SHALL go to HALT with trap=1 and halted=1.
REQ-038 Without INVALID_OPCODE_TRAP_EN, opcodes B-E SHALL be 1-byte NOPs: DECODE's wPC, then FETCH; no trap port.

Verification
REQ-039 The bench SHALL cover the following directed scenarios:
- ROM 0x00 = 0x80, 0x01 = 0x42 -> JUMP: exactly 2 wPC pulses, branch=1 and ijump=1 on the second, operand=0x42.
- JUMPZ (0x90, 0xA0) with ALU flag Z=0 -> branch=1, ijump=0, flagSel=0; the PC advances to the byte after the operand.
- INBOX (0x00) with inboxEmpty=1 for 5 cycles, then 0 -> no strobes while waiting; then one cycle with rInbox=1, wR=1, muxR=00.
- BUMPUP (0x60, 0x07) -> operand=0x07; MEM_RD then EXEC with wR=wM=1, aluOp=10, wPC=1.
- rst pulsed during WAIT_IO of OUTBOX with outboxFull=1 -> all outputs 0 at once; fetch restarts.
- Opcode 0xB0 -> trap=1, halted=1 with the macro; NOP and next fetch without it.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if -- bus between the control unit and the CPU datapath
//   (program counter, program ROM, data RAM, register R, ALU, INBOX/OUTBOX).
//
// Signals (direction as seen by the control unit, modport master):
//   in  progData[7:0]  program ROM data (1-cycle synchronous read at PC)
//   in  inboxEmpty     INBOX FIFO empty
//   in  outboxFull     OUTBOX FIFO full
//   in  memData[7:0]   data RAM read data (consumed by the datapath)
//   out wPC            PC update strobe
//   out branch         PC load-jump qualifier
//   out ijump          unconditional jump
//   out flagSel        ALU flag routed to the PC: 0=Z, 1=N
//   out operand[7:0]   latched operand byte (PC jmpAddr and RAM address)
//   out wR             register R write strobe
//   out muxR[1:0]      R source: 00=inbox, 01=RAM, 10=ALU
//   out aluOp[1:0]     00=R+M, 01=R-M, 10=M+1, 11=M-1
//   out wM             RAM write strobe
//   out rInbox         inbox pop strobe
//   out wOutbox        outbox push strobe
//   out halted         CPU stopped
//   out trap           invalid opcode seen (only with INVALID_OPCODE_TRAP_EN)
//
// Build option: define INVALID_OPCODE_TRAP_EN to add the trap signal.
interface control_unit_if;
  logic [7:0] progData;
  logic       inboxEmpty;
  logic       outboxFull;
  logic [7:0] memData;
  logic       wPC;
  logic       branch;
  logic       ijump;
  logic       flagSel;
  logic [7:0] operand;
  logic       wR;
  logic [1:0] muxR;
  logic [1:0] aluOp;
  logic       wM;
  logic       rInbox;
  logic       wOutbox;
  logic       halted;
`ifdef INVALID_OPCODE_TRAP_EN
  logic       trap;

  modport master (
    input  progData, inboxEmpty, outboxFull, memData,
    output wPC, branch, ijump, flagSel, operand, wR, muxR, aluOp,
           wM, rInbox, wOutbox, halted, trap
  );

  modport slave (
    output progData, inboxEmpty, outboxFull, memData,
    input  wPC, branch, ijump, flagSel, operand, wR, muxR, aluOp,
           wM, rInbox, wOutbox, halted, trap
  );
`else
  modport master (
    input  progData, inboxEmpty, outboxFull, memData,
    output wPC, branch, ijump, flagSel, operand, wR, muxR, aluOp,
           wM, rInbox, wOutbox, halted
  );

  modport slave (
    output progData, inboxEmpty, outboxFull, memData,
    input  wPC, branch, ijump, flagSel, operand, wR, muxR, aluOp,
           wM, rInbox, wOutbox, halted
  );
`endif
endinterface

// File: rtl/control_unit.sv
// control_unit -- multi-cycle instruction sequencer for a small
// accumulator CPU (INBOX/OUTBOX, RAM copy, ADD/SUB/BUMP, jumps, HALT).
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   control_unit_if.master (ROM/RAM/FIFO inputs, datapath strobes)
//
// Instruction flow:
//   FETCH -> DECODE -> FETCH_OP -> LOAD_OP -> [MEM_RD] -> EXEC -> FETCH
//   FETCH -> DECODE -> WAIT_IO -> FETCH            (INBOX / OUTBOX)
//   FETCH -> DECODE -> HALT                        (HALT, sticky)
// All outputs are registers: a strobe is loaded on the edge that enters
// the state it belongs to, so it is visible for exactly that state's cycle.
//
// Build option: INVALID_OPCODE_TRAP_EN -- opcodes B..E halt and raise
// trap; when undefined they are 1-byte NOPs.
module control_unit (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_FETCH_OP, S_LOAD_OP,
    S_EXEC, S_MEM_RD, S_WAIT_IO, S_HALT
  } state_t;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPUP   = 4'h6;
  localparam logic [3:0] OP_BUMPDN   = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  state_t     r_state;
  logic [7:0] r_ir;
  logic [7:0] r_operand;
  logic       r_wPC, r_branch, r_ijump, r_flagSel;
  logic       r_wR, r_wM, r_rInbox, r_wOutbox, r_halted;
  logic [1:0] r_muxR, r_aluOp;
  logic       r_io_done;
`ifdef INVALID_OPCODE_TRAP_EN
  logic       r_trap;
`endif

  logic [3:0] w_new_op;
  logic [3:0] w_op;
  logic       w_ram_rd;
  logic       w_alu_op;
  logic       w_io_ready;
  logic       w_to_exec;
  logic       w_x_branch, w_x_ijump, w_x_flagSel, w_x_wR, w_x_wM;
  logic [1:0] w_x_muxR;
  logic       w_unused;

  assign w_new_op = bus.progData[7:4];
  assign w_op     = r_ir[7:4];
  // ADD, SUB, BUMPUP, BUMPDN are 0x4..0x7; their low bits are the ALU op.
  assign w_alu_op = (w_op[3:2] == 2'b01);
  assign w_io_ready = (w_op == OP_INBOX) ? !bus.inboxEmpty : !bus.outboxFull;
  assign w_to_exec  = ((r_state == S_LOAD_OP) && !w_ram_rd) ||
                      (r_state == S_MEM_RD);
  // memData feeds the datapath only; the IR low nibble carries no meaning.
  assign w_unused = ^{bus.memData, r_ir[3:0]};

  // EXEC-cycle controls for the instruction held in IR.
  always_comb begin
    w_ram_rd    = 1'b0;
    w_x_branch  = 1'b0;
    w_x_ijump   = 1'b0;
    w_x_flagSel = 1'b0;
    w_x_wR      = 1'b0;
    w_x_wM      = 1'b0;
    w_x_muxR    = 2'b00;
    case (w_op)
      OP_COPYFROM: begin
        w_ram_rd = 1'b1;
        w_x_wR   = 1'b1;
        w_x_muxR = 2'b01;
      end
      OP_COPYTO: w_x_wM = 1'b1;
      OP_ADD, OP_SUB: begin
        w_ram_rd = 1'b1;
        w_x_wR   = 1'b1;
        w_x_muxR = 2'b10;
      end
      OP_BUMPUP, OP_BUMPDN: begin
        w_ram_rd = 1'b1;
        w_x_wR   = 1'b1;
        w_x_wM   = 1'b1;
        w_x_muxR = 2'b10;
      end
      OP_JUMP: begin
        w_x_branch = 1'b1;
        w_x_ijump  = 1'b1;
      end
      OP_JUMPZ: w_x_branch = 1'b1;
      OP_JUMPN: begin
        w_x_branch  = 1'b1;
        w_x_flagSel = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= 8'h00;
      r_operand <= 8'h00;
      r_wPC     <= 1'b0;
      r_branch  <= 1'b0;
      r_ijump   <= 1'b0;
      r_flagSel <= 1'b0;
      r_wR      <= 1'b0;
      r_wM      <= 1'b0;
      r_rInbox  <= 1'b0;
      r_wOutbox <= 1'b0;
      r_halted  <= 1'b0;
      r_muxR    <= 2'b00;
      r_aluOp   <= 2'b00;
      r_io_done <= 1'b0;
`ifdef INVALID_OPCODE_TRAP_EN
      r_trap    <= 1'b0;
`endif
    end else begin
      // Strobes live for one cycle unless the next state reloads them.
      r_wPC     <= 1'b0;
      r_branch  <= 1'b0;
      r_ijump   <= 1'b0;
      r_flagSel <= 1'b0;
      r_wR      <= 1'b0;
      r_wM      <= 1'b0;
      r_rInbox  <= 1'b0;
      r_wOutbox <= 1'b0;
      r_muxR    <= 2'b00;

      case (r_state)
        S_FETCH: begin
          // DECODE bumps the PC past the opcode byte.
          r_state <= S_DECODE;
          r_wPC   <= 1'b1;
        end
        S_DECODE: begin
          r_ir <= bus.progData;
          case (w_new_op)
            OP_INBOX, OP_OUTBOX: r_state <= S_WAIT_IO;
            OP_COPYFROM, OP_COPYTO, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN,
            OP_JUMP, OP_JUMPZ, OP_JUMPN: r_state <= S_FETCH_OP;
            OP_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: begin
`ifdef INVALID_OPCODE_TRAP_EN
              r_state  <= S_HALT;
              r_halted <= 1'b1;
              r_trap   <= 1'b1;
`else
              r_state  <= S_FETCH;
`endif
            end
          endcase
        end
        S_FETCH_OP: r_state <= S_LOAD_OP;
        S_LOAD_OP: begin
          r_operand <= bus.progData;
          if (w_ram_rd) begin
            r_state <= S_MEM_RD;
            if (w_alu_op) r_aluOp <= w_op[1:0];
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_MEM_RD: r_state <= S_EXEC;
        S_EXEC: begin
          r_state <= S_FETCH;
          r_aluOp <= 2'b00;
        end
        S_WAIT_IO: begin
          // The release strobes get their own WAIT_IO cycle: the first edge
          // that sees the FIFO ready loads them, the following edge leaves.
          if (r_io_done) begin
            r_io_done <= 1'b0;
            r_state   <= S_FETCH;
          end else if (w_io_ready) begin
            r_io_done <= 1'b1;
            if (w_op == OP_INBOX) begin
              r_rInbox <= 1'b1;
              r_wR     <= 1'b1;
            end else begin
              r_wOutbox <= 1'b1;
            end
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase

      // Entering EXEC: one cycle of PC update plus the instruction's strobes.
      if (w_to_exec) begin
        r_wPC     <= 1'b1;
        r_branch  <= w_x_branch;
        r_ijump   <= w_x_ijump;
        r_flagSel <= w_x_flagSel;
        r_wR      <= w_x_wR;
        r_wM      <= w_x_wM;
        r_muxR    <= w_x_muxR;
      end
    end
  end

  assign bus.wPC     = r_wPC;
  assign bus.branch  = r_branch;
  assign bus.ijump   = r_ijump;
  assign bus.flagSel = r_flagSel;
  assign bus.operand = r_operand;
  assign bus.wR      = r_wR;
  assign bus.muxR    = r_muxR;
  assign bus.aluOp   = r_aluOp;
  assign bus.wM      = r_wM;
  assign bus.rInbox  = r_rInbox;
  assign bus.wOutbox = r_wOutbox;
  assign bus.halted  = r_halted;
`ifdef INVALID_OPCODE_TRAP_EN
  assign bus.trap    = r_trap;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- directed bench for control_unit. Models the program
// counter and a 1-cycle synchronous program ROM around the DUT and checks
// the strobes cycle by cycle against hand-derived sequences.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] rom [256];
  logic [7:0] pc;
  logic       zflag, nflag;
  int checks = 0;
  int errors = 0;

  // Environment: PC register and program ROM.
  always @(posedge clk) bus.progData <= rom[pc];
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 8'h00;
    else if (bus.wPC) begin
      if (bus.branch && (bus.ijump || (bus.flagSel ? nflag : zflag)))
        pc <= bus.operand;
      else
        pc <= pc + 8'h01;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // {wPC, wR, wM, rInbox, wOutbox}
  function automatic logic [4:0] strb();
    return {bus.wPC, bus.wR, bus.wM, bus.rInbox, bus.wOutbox};
  endfunction

  function automatic logic [31:0] all_out();
    return {11'd0, bus.wPC, bus.branch, bus.ijump, bus.flagSel, bus.operand,
            bus.wR, bus.muxR, bus.aluOp, bus.wM, bus.rInbox, bus.wOutbox,
            bus.halted};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  // Reset, then release so the next rising edge is the first FETCH edge.
  task automatic start();
    rst = 1'b1;
    #1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [7:0] opnd, input bit mem_rd,
                        input logic [4:0] exp_strb, input logic [1:0] exp_mux,
                        input logic [1:0] exp_alu);
    clear_rom();
    rom[0] = op;
    rom[1] = opnd;
    start();
    step();  // DECODE
    check_val({tag, "_dec"}, strb(), 5'b10000);
    step();  // FETCH_OP
    step();  // LOAD_OP
    if (mem_rd) begin
      step();  // MEM_RD
      check_val({tag, "_mrd_strb"}, strb(), 5'b00000);
      check_val({tag, "_mrd_opnd"}, bus.operand, opnd);
    end
    step();  // EXEC
    check_val({tag, "_exec_strb"}, strb(), exp_strb);
    check_val({tag, "_exec_mux"}, bus.muxR, exp_mux);
    check_val({tag, "_exec_alu"}, bus.aluOp, exp_alu);
    check_val({tag, "_exec_br"}, bus.branch, 1'b0);
    check_val({tag, "_opnd"}, bus.operand, opnd);
    step();  // FETCH
    check_val({tag, "_after"}, strb(), 5'b00000);
    check_val({tag, "_pc"}, pc, 8'h02);
  endtask

  task automatic run_jump(input string tag, input logic [7:0] op,
                          input logic [7:0] opnd, input logic z, input logic n,
                          input logic exp_ij, input logic exp_fs,
                          input logic [7:0] exp_pc);
    int npc;
    clear_rom();
    rom[0] = op;
    rom[1] = opnd;
    zflag  = z;
    nflag  = n;
    npc    = 0;
    start();
    for (int c = 0; c < 3; c++) begin  // DECODE, FETCH_OP, LOAD_OP
      step();
      npc += int'(bus.wPC);
    end
    step();  // EXEC
    npc += int'(bus.wPC);
    check_val({tag, "_wpc"}, bus.wPC, 1'b1);
    check_val({tag, "_branch"}, bus.branch, 1'b1);
    check_val({tag, "_ijump"}, bus.ijump, exp_ij);
    check_val({tag, "_flagsel"}, bus.flagSel, exp_fs);
    check_val({tag, "_opnd"}, bus.operand, opnd);
    step();  // FETCH
    npc += int'(bus.wPC);
    check_val({tag, "_npc"}, npc, 2);
    check_val({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    bus.inboxEmpty = 1'b0;
    bus.outboxFull = 1'b0;
    bus.memData    = 8'h00;
    zflag = 1'b0;
    nflag = 1'b0;
    clear_rom();

    // Reset state
    #2 rst = 1'b1;
    step();
    check_val("rst_outputs", all_out(), 32'd0);
`ifdef INVALID_OPCODE_TRAP_EN
    check_val("rst_trap", bus.trap, 1'b0);
`endif

    // Jumps; JUMP lands on a HALT at 0x42, which must stay halted.
    run_jump("jump", 8'h80, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42);
    step();  // DECODE of HALT
    check_val("halt_dec", strb(), 5'b10000);
    step();
    check_val("halt_flag", bus.halted, 1'b1);
    repeat (5) step();
    check_val("halt_sticky", bus.halted, 1'b1);
    check_val("halt_strb", strb(), 5'b00000);
    run_jump("jumpz_nt", 8'h90, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02);
    run_jump("jumpz_t", 8'h90, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30);
    run_jump("jumpn_t", 8'hA0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10);

    // Two-byte data instructions
    run_op("copyfrom", 8'h20, 8'h33, 1'b1, 5'b11000, 2'b01, 2'b00);
    run_op("copyto",   8'h30, 8'h09, 1'b0, 5'b10100, 2'b00, 2'b00);
    run_op("add",      8'h40, 8'h05, 1'b1, 5'b11000, 2'b10, 2'b00);
    run_op("sub",      8'h50, 8'h06, 1'b1, 5'b11000, 2'b10, 2'b01);
    run_op("bumpup",   8'h60, 8'h07, 1'b1, 5'b11100, 2'b10, 2'b10);
    run_op("bumpdn",   8'h70, 8'h08, 1'b1, 5'b11100, 2'b10, 2'b11);

    // INBOX held off for 5 cycles
    clear_rom();
    rom[0] = 8'h00;
    bus.inboxEmpty = 1'b1;
    start();
    step();
    check_val("inbox_dec", strb(), 5'b10000);
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("inbox_wait", strb(), 5'b00000);
    end
    bus.inboxEmpty = 1'b0;
    step();
    check_val("inbox_rel", strb(), 5'b01010);
    check_val("inbox_mux", bus.muxR, 2'b00);
    step();
    check_val("inbox_after", strb(), 5'b00000);

    // OUTBOX with room
    clear_rom();
    rom[0] = 8'h10;
    bus.outboxFull = 1'b0;
    start();
    step();
    check_val("outbox_dec", strb(), 5'b10000);
    step();
    check_val("outbox_wait", strb(), 5'b00000);
    step();
    check_val("outbox_rel", strb(), 5'b00001);
    step();
    check_val("outbox_after", strb(), 5'b00000);
    step();
    check_val("outbox_next", strb(), 5'b10000);
    step();
    check_val("outbox_halt", bus.halted, 1'b1);

    // Reset during OUTBOX wait (preceded by COPYFROM so operand is nonzero)
    clear_rom();
    rom[0] = 8'h20;
    rom[1] = 8'h33;
    rom[2] = 8'h10;
    bus.outboxFull = 1'b1;
    start();
    repeat (8) step();  // through DECODE of OUTBOX, into WAIT_IO
    step();
    check_val("rstio_opnd", bus.operand, 8'h33);
    check_val("rstio_wait", strb(), 5'b00000);
    #1 rst = 1'b1;
    #1;
    check_val("rstio_outputs", all_out(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.outboxFull = 1'b0;
    step();
    check_val("rstio_refetch", strb(), 5'b10000);
    repeat (3) step();  // FETCH_OP, LOAD_OP, MEM_RD
    check_val("rstio_reopnd", bus.operand, 8'h33);

    // Unknown opcode 0xB0
    clear_rom();
    rom[0] = 8'hB0;
    start();
    step();
    check_val("bad_dec", strb(), 5'b10000);
    step();
`ifdef INVALID_OPCODE_TRAP_EN
    check_val("bad_trap", bus.trap, 1'b1);
    check_val("bad_halted", bus.halted, 1'b1);
    check_val("bad_strb", strb(), 5'b00000);
    step();
    check_val("bad_sticky", {bus.trap, bus.halted, strb()}, 7'b1100000);
`else
    check_val("bad_nop_halted", bus.halted, 1'b0);
    check_val("bad_nop_strb", strb(), 5'b00000);
    step();
    check_val("bad_next_dec", strb(), 5'b10000);
    step();
    check_val("bad_next_halt", bus.halted, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
